// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion, pointer type and
// synchroniser limits used by the pointer synchronisers and their siblings.
package fifo_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned PTR_ADDRSIZE    = 4;
  localparam int unsigned CODE_W_MAX      = 32;

  typedef logic [PTR_ADDRSIZE:0] ptr_t;

  // Callers zero-extend into CODE_W_MAX bits; bits at or above width are ignored.
  function automatic logic [CODE_W_MAX-1:0] gray2bin(input logic [CODE_W_MAX-1:0] g,
                                                     input int unsigned width);
    logic [CODE_W_MAX:0]   acc;
    logic [CODE_W_MAX-1:0] g_m;
    for (int i = 0; i < CODE_W_MAX; i++) begin
      g_m[i] = (i < width) ? g[i] : 1'b0;
    end
    acc = '0;
    for (int i = CODE_W_MAX - 1; i >= 0; i--) begin
      acc[i] = acc[i+1] ^ g_m[i];
    end
    return acc[CODE_W_MAX-1:0];
  endfunction

  function automatic logic [CODE_W_MAX-1:0] bin2gray(input logic [CODE_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_ptr_gray_if.sv
// Pointer synchroniser bus: foreign Gray pointer and error clear in,
// synchronised Gray/binary pointer, advance and status out.
interface sync_ptr_gray_if #(
  parameter int unsigned ADDRSIZE = 4
);

  logic [ADDRSIZE:0] ptr_gray_in;
  logic              err_clr;
  logic [ADDRSIZE:0] sync_gray;
  logic [ADDRSIZE:0] sync_bin;
  logic [ADDRSIZE:0] ptr_delta;
  logic              delta_nz;
  logic              sync_valid;
  logic              gray_err;

  modport master (
    output ptr_gray_in, err_clr,
    input  sync_gray, sync_bin, ptr_delta, delta_nz, sync_valid, gray_err
  );

  modport slave (
    input  ptr_gray_in, err_clr,
    output sync_gray, sync_bin, ptr_delta, delta_nz, sync_valid, gray_err
  );

endinterface

// File: rtl/sync_stage_chain.sv
// Plain async-reset register chain used as a clock-domain synchroniser;
// no logic between stages. STAGES must be at least 2.
module sync_stage_chain #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_last,
  output logic [WIDTH-1:0] q_prev
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // shift chain, stage 0 samples the foreign-domain input
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      stage_r <= '0;
    end else begin
      stage_r <= {stage_r[STAGES-2:0], d};
    end
  end

  assign q_last = stage_r[STAGES-1];
  assign q_prev = stage_r[STAGES-2];

endmodule

// File: rtl/sync_ptr_gray.sv
// N-flop Gray pointer synchroniser with registered binary copy, per-cycle
// pointer advance, fill tracking and a sticky multi-bit Gray change flag.
module sync_ptr_gray
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned STAGES   = 2
) (
  input  logic           wclk,
  input  logic           wrst,
  sync_ptr_gray_if.slave bus
);

  localparam int unsigned PTR_W    = ADDRSIZE + 1;
  localparam int unsigned FILL_MAX = STAGES + 1;
  localparam int unsigned FILL_W   = $clog2(FILL_MAX + 1);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_check
    $error("sync_ptr_gray: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [PTR_W-1:0]  sync_last_s;
  logic [PTR_W-1:0]  sync_prev_s;
  logic [PTR_W-1:0]  sync_bin_s;
  logic [PTR_W-1:0]  delta_s;
  logic              delta_nz_s;
  logic [FILL_W-1:0] fill_s;
  logic              valid_s;
  logic              multibit_s;
  logic              err_s;

  logic [PTR_W-1:0]  sync_bin_r;
  logic [PTR_W-1:0]  delta_r;
  logic              delta_nz_r;
  logic [FILL_W-1:0] fill_r;
  logic              sync_valid_r;
  logic              gray_err_r;

  sync_stage_chain #(
    .WIDTH  (PTR_W),
    .STAGES (STAGES)
  ) u_chain (
    .wclk   (wclk),
    .wrst   (wrst),
    .d      (bus.ptr_gray_in),
    .q_last (sync_last_s),
    .q_prev (sync_prev_s)
  );

  // sync_bin_r doubles as the previous-binary register for the advance
  always_comb begin
    sync_bin_s = PTR_W'(gray2bin(CODE_W_MAX'(sync_last_s), PTR_W));
    delta_s    = '0;
    if (sync_valid_r) begin
      delta_s = sync_bin_s - sync_bin_r;
    end else begin
      delta_s = '0;
    end
    delta_nz_s = (delta_s != '0);

    fill_s = fill_r;
    if (fill_r == FILL_W'(FILL_MAX)) begin
      fill_s = fill_r;
    end else begin
      fill_s = fill_r + FILL_W'(1);
    end
    valid_s = sync_valid_r | (fill_s == FILL_W'(FILL_MAX));

    // stage[STAGES-2] is the next value of the last stage; set beats clear
    multibit_s = ($countones(sync_last_s ^ sync_prev_s) > 32'sd1);
    err_s      = gray_err_r;
    if (sync_valid_r && multibit_s) begin
      err_s = 1'b1;
    end else if (bus.err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = gray_err_r;
    end
  end

  // output and status registers
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      sync_bin_r   <= '0;
      delta_r      <= '0;
      delta_nz_r   <= 1'b0;
      fill_r       <= '0;
      sync_valid_r <= 1'b0;
      gray_err_r   <= 1'b0;
    end else begin
      sync_bin_r   <= sync_bin_s;
      delta_r      <= delta_s;
      delta_nz_r   <= delta_nz_s;
      fill_r       <= fill_s;
      sync_valid_r <= valid_s;
      gray_err_r   <= err_s;
    end
  end

  assign bus.sync_gray  = sync_last_s;
  assign bus.sync_bin   = sync_bin_r;
  assign bus.ptr_delta  = delta_r;
  assign bus.delta_nz   = delta_nz_r;
  assign bus.sync_valid = sync_valid_r;
  assign bus.gray_err   = gray_err_r;

endmodule

// File: tb/tb_sync_ptr_gray.sv
// Bench for sync_ptr_gray: STAGES=2 and STAGES=3 instances share one input
// pointer and are checked every cycle against a history-based reference.
module tb_sync_ptr_gray;

  localparam int AW = 4;

  logic       wclk = 1'b0;
  logic       wrst;
  logic [4:0] ptr;
  logic       clr [2];

  always #5 wclk = ~wclk;

  sync_ptr_gray_if #(.ADDRSIZE(AW)) bus2 ();
  sync_ptr_gray_if #(.ADDRSIZE(AW)) bus3 ();

  assign bus2.ptr_gray_in = ptr;
  assign bus3.ptr_gray_in = ptr;
  assign bus2.err_clr     = clr[0];
  assign bus3.err_clr     = clr[1];

  sync_ptr_gray #(.ADDRSIZE(AW), .STAGES(2)) dut2 (.wclk(wclk), .wrst(wrst), .bus(bus2.slave));
  sync_ptr_gray #(.ADDRSIZE(AW), .STAGES(3)) dut3 (.wclk(wclk), .wrst(wrst), .bus(bus3.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // reference: every input sample since reset release, per instance
  int         st [2] = '{2, 3};
  int         n  [2];
  logic [4:0] hist [2][0:4095];
  logic       err_m [2];
  int         cb;

  function automatic logic [4:0] to_gray(input int b);
    return 5'((b ^ (b >> 1)) & 31);
  endfunction

  function automatic logic [4:0] g2b_ref(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (to_gray(b) == g) return 5'(b);
    end
    return 5'd0;
  endfunction

  function automatic logic [4:0] m_gray(input int i, input int m);
    if (m >= st[i]) return hist[i][m - st[i]];
    return 5'd0;
  endfunction

  function automatic logic [4:0] m_bin(input int i, input int m);
    if (m >= st[i] + 1) return g2b_ref(hist[i][m - st[i] - 1]);
    return 5'd0;
  endfunction

  function automatic logic m_valid(input int i, input int m);
    return (m >= st[i] + 1);
  endfunction

  function automatic logic [4:0] m_delta(input int i, input int m);
    if (m >= 1 && m_valid(i, m - 1)) return 5'(m_bin(i, m) - m_bin(i, m - 1));
    return 5'd0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [4:0] og, ob, od;
    logic       onz, ov, oe;
    logic [4:0] ed;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        og = bus2.sync_gray; ob = bus2.sync_bin; od = bus2.ptr_delta;
        onz = bus2.delta_nz; ov = bus2.sync_valid; oe = bus2.gray_err;
      end else begin
        og = bus3.sync_gray; ob = bus3.sync_bin; od = bus3.ptr_delta;
        onz = bus3.delta_nz; ov = bus3.sync_valid; oe = bus3.gray_err;
      end
      ed = m_delta(i, n[i]);
      check_val($sformatf("%s.s%0d.sync_gray", ph, st[i]), 32'(og), 32'(m_gray(i, n[i])));
      check_val($sformatf("%s.s%0d.sync_bin", ph, st[i]), 32'(ob), 32'(m_bin(i, n[i])));
      check_val($sformatf("%s.s%0d.ptr_delta", ph, st[i]), 32'(od), 32'(ed));
      check_val($sformatf("%s.s%0d.delta_nz", ph, st[i]), 32'(onz), 32'(ed != 5'd0));
      check_val($sformatf("%s.s%0d.sync_valid", ph, st[i]), 32'(ov), 32'(m_valid(i, n[i])));
      check_val($sformatf("%s.s%0d.gray_err", ph, st[i]), 32'(oe), 32'(err_m[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n[i]     = 0;
      err_m[i] = 1'b0;
    end
  endtask

  task automatic tick(input string ph);
    logic [4:0] g_old;
    logic       v_old;
    @(posedge wclk);
    if (wrst) begin
      for (int i = 0; i < 2; i++) begin
        g_old = m_gray(i, n[i]);
        v_old = m_valid(i, n[i]);
        if (n[i] < 4095) begin
          hist[i][n[i]] = ptr;
          n[i]++;
        end
        if (v_old && ($countones(m_gray(i, n[i]) ^ g_old) >= 2)) err_m[i] = 1'b1;
        else if (clr[i]) err_m[i] = 1'b0;
      end
    end
    #1;
    check_all(ph);
  endtask

  initial begin
    wrst = 1'b1; ptr = 5'd0; clr[0] = 1'b0; clr[1] = 1'b0;
    model_reset();
    #1 wrst = 1'b0;
    #1 check_all("reset");
    #20 wrst = 1'b1;

    // 1: idle pointer, pipeline fill
    tick("idle"); tick("idle");
    check_val("t1.s2.valid_before_edge3", 32'(bus2.sync_valid), 32'd0);
    tick("idle");
    check_val("t1.s2.valid_edge3", 32'(bus2.sync_valid), 32'd1);
    tick("idle"); tick("idle");

    // 2: full Gray walk including the 31 -> 0 wrap
    for (int k = 1; k <= 32; k++) begin
      ptr = to_gray(k % 32);
      tick("walk");
    end
    check_val("t2.s2.delta_wrap", 32'(bus2.ptr_delta), 32'd1);
    repeat (4) tick("walk_hold");

    // 3: three-bit jump 0 -> Gray(5), then clear
    ptr = 5'b00111;
    repeat (5) tick("jump");
    check_val("t3.s3.sync_bin", 32'(bus3.sync_bin), 32'd5);
    check_val("t3.s3.gray_err", 32'(bus3.gray_err), 32'd1);
    clr[0] = 1'b1; clr[1] = 1'b1;
    tick("clr");
    clr[0] = 1'b0; clr[1] = 1'b0;
    check_val("t3.s3.err_cleared", 32'(bus3.gray_err), 32'd0);

    // 4: multi-bit change while the pipeline refills
    #2 wrst = 1'b0;
    model_reset();
    #1 check_all("rst4");
    ptr = 5'd0;
    tick("rst4_hold"); tick("rst4_hold");
    #3 wrst = 1'b1; ptr = 5'b10101;
    repeat (6) tick("fill_err");
    check_val("t4.s2.no_err", 32'(bus2.gray_err), 32'd0);
    check_val("t4.s3.no_err", 32'(bus3.gray_err), 32'd0);

    // 5: clear coincides with a new error, set wins
    ptr = 5'b01010;
    tick("setclr");
    clr[0] = 1'b1;
    tick("setclr");
    clr[0] = 1'b0; clr[1] = 1'b1;
    tick("setclr");
    clr[1] = 1'b0;
    check_val("t5.s2.set_wins", 32'(bus2.gray_err), 32'd1);
    check_val("t5.s3.set_wins", 32'(bus3.gray_err), 32'd1);
    clr[0] = 1'b1; clr[1] = 1'b1;
    tick("setclr_clear");
    clr[0] = 1'b0; clr[1] = 1'b0;

    // 6: reset mid-stream at pointer 13 and re-acquire
    ptr = to_gray(13);
    repeat (5) tick("at13");
    #2 wrst = 1'b0;
    model_reset();
    #1 check_all("rst6_async");
    tick("rst6_hold"); tick("rst6_hold");
    #3 wrst = 1'b1;
    repeat (5) tick("reacq");
    check_val("t6.s2.bin13", 32'(bus2.sync_bin), 32'd13);
    check_val("t6.s3.bin13", 32'(bus3.sync_bin), 32'd13);
    check_val("t6.s3.no_err", 32'(bus3.gray_err), 32'd0);

    // randomized advance, including multi-step jumps and random clears
    cb = 13;
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 8) cb = cb + 1;
      else if (r < 11) cb = cb + int'($urandom_range(2, 3));
      else if (r == 15) cb = int'($urandom_range(0, 31));
      cb = cb % 32;
      ptr = to_gray(cb);
      clr[0] = ($urandom_range(0, 7) == 0);
      clr[1] = ($urandom_range(0, 7) == 0);
      tick("rand");
    end
    clr[0] = 1'b0; clr[1] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
